// File: rtl/mem_pkg.sv
// Shared widths and access-FSM state encoding for the memory unit.
package mem_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RAM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ram256x8.sv
// 256x8 RAM with one write port. The read address is decoded here, and the
// read data is registered by the MBR in the parent, which gives a one-cycle
// synchronous read. Contents are never cleared by reset.
module ram256x8
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_unit.sv
// Memory unit: PC, MAR, MBR and IR registers around a 256x8 RAM that is shared
// by the program-preload port and the CPU. The preload port always wins the
// RAM write port.
// Define MEM_UNIT_WAIT_EN to add one wait state to every RAM read and write.
module mem_unit
  import mem_pkg::*;
(
  input  logic              MEM_clk,
  input  logic              MEM_rst,
  input  logic              MAR_we,
  input  logic              MAR_mux,
  input  logic              MBR_we,
  input  logic              MBR_mux,
  input  logic              RAM_we,
  input  logic              IR_we,
  input  logic              PC_inc,
  input  logic [DATA_W-1:0] st_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MBR,
  output logic [DATA_W-1:0] IR,
  output logic              mem_rdy,
  output logic              mem_ovr
);

  logic              st_load_c;
  logic              rd_req_c;
  logic              cpu_wr_c;
  logic              mbr_rd_load_c;
  logic              ovr_set_c;
  logic [ADDR_W-1:0] cpu_waddr_c;
  logic [DATA_W-1:0] cpu_wdata_c;
  logic [ADDR_W-1:0] ram_raddr_c;
  logic [DATA_W-1:0] ram_rdata_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c;

  assign st_load_c = MBR_we & MBR_mux;
  assign rd_req_c  = MBR_we & ~MBR_mux;

`ifdef MEM_UNIT_WAIT_EN
  mem_state_t        state;
  mem_state_t        state_nxt;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // Access FSM state register.
  always_ff @(posedge MEM_clk or posedge MEM_rst) begin
    if (MEM_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and access strobes; strobes arriving while busy are lost.
  always_comb begin
    state_nxt     = state;
    cpu_wr_c      = 1'b0;
    mbr_rd_load_c = 1'b0;
    ovr_set_c     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req_c) begin
          state_nxt = RD_WAIT;
          ovr_set_c = RAM_we;
        end else if (RAM_we) begin
          if (prog_we) ovr_set_c = 1'b1;
          else         state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: begin
        state_nxt     = IDLE;
        mbr_rd_load_c = 1'b1;
        ovr_set_c     = rd_req_c | RAM_we;
      end
      WR_WAIT: begin
        state_nxt = IDLE;
        cpu_wr_c  = ~prog_we;
        ovr_set_c = rd_req_c | RAM_we | prog_we;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are frozen at the request edge.
  always_ff @(posedge MEM_clk or posedge MEM_rst) begin
    if (MEM_rst) begin
      pend_addr <= '0;
      pend_data <= '0;
    end else if (state == IDLE) begin
      pend_addr <= MAR;
      pend_data <= MBR;
    end
  end

  assign cpu_waddr_c = pend_addr;
  assign cpu_wdata_c = pend_data;
  assign ram_raddr_c = pend_addr;
  assign mem_rdy     = (state == IDLE);
`else
  assign cpu_wr_c      = RAM_we & ~prog_we & ~rd_req_c;
  assign mbr_rd_load_c = rd_req_c;
  assign ovr_set_c     = RAM_we & (prog_we | rd_req_c);
  assign cpu_waddr_c   = MAR;
  assign cpu_wdata_c   = MBR;
  assign ram_raddr_c   = MAR;
  assign mem_rdy       = 1'b1;
`endif

  assign ram_we_c    = prog_we | cpu_wr_c;
  assign ram_waddr_c = prog_we ? prog_addr : cpu_waddr_c;
  assign ram_wdata_c = prog_we ? prog_data : cpu_wdata_c;

  ram256x8 u_ram (
    .clk   (MEM_clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata_c)
  );

  // Program counter, address and instruction registers.
  always_ff @(posedge MEM_clk or posedge MEM_rst) begin
    if (MEM_rst) begin
      PC  <= '0;
      MAR <= '0;
      IR  <= '0;
    end else begin
      if (PC_inc) PC <= PC + ADDR_W'(1);
      if (MAR_we) MAR <= MAR_mux ? {4'h0, IR[3:0]} : PC;
      if (IR_we)  IR  <= MBR;
    end
  end

  // MBR: a store operand load is never delayed and wins over RAM data.
  always_ff @(posedge MEM_clk or posedge MEM_rst) begin
    if (MEM_rst)            MBR <= '0;
    else if (st_load_c)     MBR <= st_data;
    else if (mbr_rd_load_c) MBR <= ram_rdata_c;
  end

  // Sticky lost-strobe flag.
  always_ff @(posedge MEM_clk or posedge MEM_rst) begin
    if (MEM_rst)        mem_ovr <= 1'b0;
    else if (ovr_set_c) mem_ovr <= 1'b1;
  end

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: stimulus pushes expected register snapshots,
// a negedge monitor pops and compares them.
module tb_mem_unit;

  logic       MEM_clk = 1'b0;
  logic       MEM_rst;
  logic       MAR_we, MAR_mux, MBR_we, MBR_mux, RAM_we, IR_we, PC_inc;
  logic [7:0] st_data;
  logic       prog_we;
  logic [7:0] prog_addr, prog_data;
  logic [7:0] PC, MAR, MBR, IR;
  logic       mem_rdy, mem_ovr;

  always #5 MEM_clk = ~MEM_clk;

  mem_unit dut (
    .MEM_clk   (MEM_clk),
    .MEM_rst   (MEM_rst),
    .MAR_we    (MAR_we),
    .MAR_mux   (MAR_mux),
    .MBR_we    (MBR_we),
    .MBR_mux   (MBR_mux),
    .RAM_we    (RAM_we),
    .IR_we     (IR_we),
    .PC_inc    (PC_inc),
    .st_data   (st_data),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .PC        (PC),
    .MAR       (MAR),
    .MBR       (MBR),
    .IR        (IR),
    .mem_rdy   (mem_rdy),
    .mem_ovr   (mem_ovr)
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] mar;
    logic [7:0] mbr;
    logic [7:0] ir;
    logic       ovr;
    logic       rdy;
  } snap_t;

  snap_t exp_q[$];
  snap_t e;
  logic  sample_req = 1'b0;
  logic  tb_done    = 1'b0;
  int    n_cmp      = 0;
  int    n_bad      = 0;

  // Reference model state.
  logic [7:0] m_ram [256];
  logic [7:0] m_pc, m_mar, m_mbr, m_ir;
  logic       m_ovr;

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compare one expected snapshot per requested sample.
  always @(negedge MEM_clk) begin
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: got sample request expected queued entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("PC", PC, e.pc);
        chk("MAR", MAR, e.mar);
        chk("MBR", MBR, e.mbr);
        chk("IR", IR, e.ir);
        chk("mem_ovr", 8'(mem_ovr), 8'(e.ovr));
        chk("mem_rdy", 8'(mem_rdy), 8'(e.rdy));
      end
    end else if (tb_done) begin
      chk("queue_left", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic push_exp(input logic rdy);
    exp_q.push_back('{m_pc, m_mar, m_mbr, m_ir, m_ovr, rdy});
    sample_req = 1'b1;
  endtask

  task automatic clear_inputs;
    MAR_we = 0; MAR_mux = 0; MBR_we = 0; MBR_mux = 0; RAM_we = 0;
    IR_we = 0; PC_inc = 0; prog_we = 0;
  endtask

  task automatic settle;
    @(posedge MEM_clk); #1;
    sample_req = 1'b0;
  endtask

  task automatic do_reset;
    if (sample_req) settle();
    clear_inputs();
    MEM_rst = 1'b1;
    m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0; m_ovr = 0;
    push_exp(1'b1);
    settle();
    MEM_rst = 1'b0;
  endtask

  // One strobe cycle, plus the wait cycle when the build has wait states.
  task automatic step(input logic a_mar_we, input logic a_mar_mux, input logic a_mbr_we,
                      input logic a_mbr_mux, input logic a_ram_we, input logic a_ir_we,
                      input logic a_pc_inc, input logic a_pw, input logic [7:0] a_pa,
                      input logic [7:0] a_pd, input logic [7:0] a_sd, input bit check);
    logic       rd;
    logic [7:0] o_pc, o_mar, o_mbr;
    MAR_we = a_mar_we; MAR_mux = a_mar_mux; MBR_we = a_mbr_we; MBR_mux = a_mbr_mux;
    RAM_we = a_ram_we; IR_we = a_ir_we; PC_inc = a_pc_inc; prog_we = a_pw;
    prog_addr = a_pa; prog_data = a_pd; st_data = a_sd;
    settle();
    clear_inputs();
`ifdef MEM_UNIT_WAIT_EN
    if ((a_mbr_we && !a_mbr_mux) || (a_ram_we && !a_pw)) settle();
`endif
    rd = a_mbr_we && !a_mbr_mux;
    o_pc = m_pc; o_mar = m_mar; o_mbr = m_mbr;
    if (a_pc_inc) m_pc = o_pc + 8'd1;
    if (a_mar_we) m_mar = a_mar_mux ? {4'h0, m_ir[3:0]} : o_pc;
    if (a_mbr_we) m_mbr = a_mbr_mux ? a_sd : m_ram[o_mar];
    if (a_ir_we)  m_ir = o_mbr;
    if (a_ram_we && (a_pw || rd)) m_ovr = 1'b1;
    else if (a_ram_we)            m_ram[o_mar] = o_mbr;
    if (a_pw) m_ram[a_pa] = a_pd;
    if (check) push_exp(1'b1);
  endtask

  initial begin
    logic       r_mar_we, r_mar_mux, r_mbr_we, r_mbr_mux, r_ram_we, r_ir_we, r_pc_inc, r_pw;
    logic [7:0] r_pa, r_pd, r_sd;
    MEM_rst = 1'b1;
    clear_inputs();
    st_data = 0; prog_addr = 0; prog_data = 0;
    @(posedge MEM_clk); #1;
    do_reset();

    // Preload the whole RAM with random bytes.
    for (int a = 0; a < 256; a++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 8'(a), 8'($urandom), 8'h00, 0);

    // Program preload survives reset and is fetched into IR.
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h0A, 8'h00, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1);

    // Load through the IR-derived address.
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, 8'h05, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h05, 8'h3C, 8'h00, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);

    // Store st_data to 0x07 and read it back.
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h07, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h99, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);

    // PC wrap with MAR capturing the pre-increment value.
    while (m_pc != 8'hFF) step(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1);

    // Preload/CPU write collision at 0x10.
    for (int k = 0; k < 16; k++) step(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'hAA, 1);
    step(0, 0, 0, 0, 1, 0, 0, 1, 8'h10, 8'h55, 8'h00, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);

    // Read/write collision drops the write.
    do_reset();
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, ~m_ram[0], 1);
    step(0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);

`ifdef MEM_UNIT_WAIT_EN
    // Read wait state: not ready for exactly one cycle, data after.
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, ~m_ram[m_mar], 1);
    MBR_we = 1; MBR_mux = 0;
    settle();
    clear_inputs();
    push_exp(1'b0);
    settle();
    m_mbr = m_ram[m_mar];
    push_exp(1'b1);

    // Reset during WR_WAIT discards the pending write.
    do_reset();
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, ~m_ram[0], 1);
    RAM_we = 1;
    settle();
    clear_inputs();
    do_reset();
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if (i % 64 == 63) do_reset();
      r_mar_we  = 1'($urandom_range(0, 2) == 0);
      r_mar_mux = 1'($urandom_range(0, 1));
      r_mbr_we  = 1'($urandom_range(0, 1));
      r_mbr_mux = 1'($urandom_range(0, 1));
      r_ram_we  = 1'($urandom_range(0, 3) == 0);
      r_ir_we   = 1'($urandom_range(0, 3) == 0);
      r_pc_inc  = 1'($urandom_range(0, 1));
      r_pw      = 1'($urandom_range(0, 7) == 0);
      r_pa      = 8'($urandom);
      r_pd      = 8'($urandom);
      r_sd      = 8'($urandom);
      if (r_pw && r_mbr_we && !r_mbr_mux) r_pw = 1'b0;
      step(r_mar_we, r_mar_mux, r_mbr_we, r_mbr_mux, r_ram_we, r_ir_we, r_pc_inc,
           r_pw, r_pa, r_pd, r_sd, 1);
    end

    settle();
    tb_done = 1'b1;
  end

endmodule
